// File: rtl/karatsuba_acc.sv
// -----------------------------------------------------------------------------
// karatsuba_acc
//   Back end for the karatsuba multiplier: it sums a stream of P_W-bit
//   products into an ACC_W-bit accumulator and hands the closed sum out on a
//   valid/ready port. A sum closes on an accepted term that has in_last set,
//   or on the accepted term that brings the count to MAX_TERMS.
//
//   Configuration macro: KARATSUBA_ACC_SAT_EN
//     defined   -> on overflow the sum clamps to 2^ACC_W-1 and stays there
//     undefined -> the sum wraps modulo 2^ACC_W
//     In both builds ovf is sticky and set on overflow.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   clear       synchronous abort; drops any partial or held sum
//   in_valid    Z carries a product this cycle
//   in_last     final term of the sum (qualified by in_valid)
//   Z           product from the karatsuba stage
//   in_ready    accumulator can take a term (state ACCUM)
//   out_valid   acc_out holds a closed sum (state HOLD)
//   out_ready   consumer takes acc_out
//   acc_out     running/closed sum
//   term_count  number of terms in the current/held sum
//   ovf         sticky overflow flag for the current/held sum
// -----------------------------------------------------------------------------
module karatsuba_acc #(
   parameter int P_W       = 16,
   parameter int ACC_W     = 24,
   parameter int MAX_TERMS = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic [P_W-1:0]   Z,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] term_count,
   output logic             ovf
);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_TERMS);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             ovf_q,   ovf_d;

   logic [ACC_W:0]   sum_s;
   logic             carry_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [ACC_W-1:0] acc_next_s;

   // Datapath: one extra bit catches the carry out of the accumulator MSB.
   always_comb begin
      sum_s     = {1'b0, acc_q} + {{(ACC_W + 1 - P_W){1'b0}}, Z};
      carry_s   = sum_s[ACC_W];
      cnt_inc_s = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
`ifdef KARATSUBA_ACC_SAT_EN
      // Once clamped at ACC_MAX any non-zero term carries again, so the
      // clamp holds for the rest of the sum without extra state.
      if (carry_s) begin
         acc_next_s = ACC_MAX;
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
      end
`else
      acc_next_s = sum_s[ACC_W-1:0];
`endif
   end

   // Next-state logic for the ACCUM/HOLD handshake FSM and the sum registers.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_next_s;
               cnt_d = cnt_inc_s;
               ovf_d = ovf_q | carry_s;
               if (in_last || (cnt_inc_s == CNT_LIMIT)) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            // Release returns to an empty sum; the release cycle itself
            // never accepts a term because in_ready is low in HOLD.
            if (out_ready) begin
               state_d = ST_ACCUM;
               acc_d   = {ACC_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_ACCUM;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
         end
      endcase
   end

   // State and sum registers; clear behaves exactly like reset.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q <= ST_ACCUM;
         acc_q   <= {ACC_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Outputs are direct decodes of registered state.
   always_comb begin
      in_ready   = (state_q == ST_ACCUM);
      out_valid  = (state_q == ST_HOLD);
      acc_out    = acc_q;
      term_count = cnt_q;
      ovf        = ovf_q;
   end

endmodule

// File: tb/tb_karatsuba_acc.sv
// -----------------------------------------------------------------------------
// tb_karatsuba_acc
//   Directed bench for karatsuba_acc built with ACC_W=16, MAX_TERMS=4 so the
//   overflow and forced-close cases are reachable with short vectors.
//   Each closed sum that should reach the consumer is pushed into a queue; a
//   monitor pops and compares on every out_valid & out_ready beat.
// -----------------------------------------------------------------------------
module tb_karatsuba_acc;

   localparam int P_W       = 16;
   localparam int ACC_W     = 16;
   localparam int MAX_TERMS = 4;
   localparam int CNT_W     = 3;

   logic             clk;
   logic             reset;
   logic             clear;
   logic             in_valid;
   logic             in_last;
   logic [P_W-1:0]   z;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] term_count;
   logic             ovf;

   typedef struct {
      int acc;
      int cnt;
      int ovf;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   beats    = 0;

   karatsuba_acc #(
      .P_W       (P_W),
      .ACC_W     (ACC_W),
      .MAX_TERMS (MAX_TERMS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .Z          (z),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .acc_out    (acc_out),
      .term_count (term_count),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one input beat presented for one clock edge
   task automatic send(input int zv, input bit last);
      in_valid = 1'b1;
      z        = P_W'(zv);
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      z        = '0;
   endtask

   task automatic push(input int a, input int c, input int o);
      exp_t e;
      e.acc = a;
      e.cnt = c;
      e.ovf = o;
      sb.push_back(e);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_acc"},   int'(acc_out), 0);
      chk({tag, "_cnt"},   int'(term_count), 0);
      chk({tag, "_ovf"},   int'(ovf), 0);
      chk({tag, "_ovld"},  int'(out_valid), 0);
      chk({tag, "_irdy"},  int'(in_ready), 1);
   endtask

   // Monitor: every output beat must match the oldest expected sum.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         beats++;
         if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("beat_acc", int'(acc_out), e.acc);
            chk("beat_cnt", int'(term_count), e.cnt);
            chk("beat_ovf", int'(ovf), e.ovf);
         end
      end
   end

   initial begin
      int b0;
      int ovf_acc;
      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      z         = '0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk_idle("reset");

      // 1: three 256 products, last on the third
      out_ready = 1'b1;
      push(768, 3, 0);
      send(256, 1'b0);
      send(256, 1'b0);
      chk("t1_running", int'(acc_out), 512);
      send(256, 1'b1);
      chk("t1_ovld_lat", int'(out_valid), 1);
      chk("t1_irdy_hold", int'(in_ready), 0);
      tick();
      chk("t1_rel_ovld", int'(out_valid), 0);
      chk("t1_rel_irdy", int'(in_ready), 1);
      chk("t1_rel_cnt", int'(term_count), 0);

      // 2: forced close after MAX_TERMS, in_valid held during HOLD
      out_ready = 1'b0;
      push(10, 4, 0);
      send(1, 1'b0);
      send(2, 1'b0);
      send(3, 1'b0);
      send(4, 1'b0);
      chk("t2_ovld", int'(out_valid), 1);
      in_valid = 1'b1;
      z        = 16'd9;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_acc", int'(acc_out), 10);
         chk("t2_hold_cnt", int'(term_count), 4);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t2_rel_cnt", int'(term_count), 0);
      chk("t2_rel_irdy", int'(in_ready), 1);

      // 3: overflow, wrap or clamp depending on build
`ifdef KARATSUBA_ACC_SAT_EN
      ovf_acc = 32'h0000_FFFF;
`else
      ovf_acc = 32'h0000_0001;
`endif
      out_ready = 1'b1;
      push(ovf_acc, 2, 1);
      send(32'h0000_FFFF, 1'b0);
      chk("t3_pre_ovf", int'(ovf), 0);
      chk("t3_pre_acc", int'(acc_out), 32'h0000_FFFF);
      send(2, 1'b1);
      chk("t3_ovf", int'(ovf), 1);
      tick();
      chk("t3_rel_ovf", int'(ovf), 0);

      // 4: backpressure with a held sum of 5
      out_ready = 1'b0;
      push(5, 2, 0);
      send(2, 1'b0);
      send(3, 1'b1);
      in_valid = 1'b1;
      z        = 16'd50;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_acc", int'(acc_out), 5);
         chk("t4_hold_irdy", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      b0        = beats;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      chk("t4_one_beat", beats - b0, 1);

      // 5: clear drops a partial sum; the next sum starts from zero
      send(100, 1'b0);
      send(200, 1'b0);
      chk("t5_partial", int'(acc_out), 300);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_idle("t5_clear");
      out_ready = 1'b1;
      push(7, 1, 0);
      send(7, 1'b1);
      tick();

      // 6: reset and clear in HOLD (with ovf set) and mid-ACCUM
      out_ready = 1'b0;
      send(32'h0000_FFFF, 1'b0);
      send(2, 1'b1);
      chk("t6_hold_rst_pre", int'(out_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("t6_rst_hold");
      send(9, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("t6_rst_accum");
      send(32'h0000_FFFF, 1'b0);
      send(2, 1'b1);
      chk("t6_hold_clr_pre", int'(out_valid), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_idle("t6_clr_hold");
      send(9, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      z        = 16'd11;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk_idle("t6_clr_accum");
      out_ready = 1'b1;
      tick();
      tick();

      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         tick();
      end
      chk("sb_drain", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
